// File: rtl/fir_filter.sv
// 512-tap single-rate FIR: one 16x16 MAC per clock, one 48-bit result per 512-clock frame.
// Coefficients live in the mem_coeff instance and are loaded before filtering starts.

module fir_coeff_mem #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [DW-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic signed [DW-1:0] rdata
);

  logic signed [DW-1:0] mem [0:DEPTH-1];

  // Single write port plus registered read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

module fir_filter #(
  parameter int unsigned TAPS = 512
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic signed [15:0] idata,
  output logic signed [47:0] out_val,
  output logic               out_ready
);

  localparam int unsigned DW  = 16;
  localparam int unsigned PW  = 32;
  localparam int unsigned ACW = 48;
  localparam int unsigned PHW = $clog2(TAPS);
  localparam int unsigned FW  = PHW + 1;

  logic signed [DW-1:0]  hold;
  logic signed [DW-1:0]  hist [0:TAPS-1];

  logic [PHW-1:0]        phase;
  logic [PHW-1:0]        wptr;
  logic [FW-1:0]         fill;

  logic                  capture_c;
  logic [PHW-1:0]        head_c;

  logic [PHW-1:0]        addr1;
  logic [PHW-1:0]        tap1;
  logic                  v1, first1, last1, live1;

  logic signed [DW-1:0]  smp2;
  logic signed [DW-1:0]  coef2;
  logic                  v2, first2, last2, live2;

  logic signed [PW-1:0]  prod3;
  logic                  v3, first3, last3;

  logic signed [ACW-1:0] acc;
  logic                  last4;

  logic signed [ACW-1:0] sum5;
  logic                  sum_v;

  logic [PW-1:0]         smp_ext_c;
  logic [PW-1:0]         coef_ext_c;
  logic [PW-1:0]         prod_c;
  logic signed [ACW-1:0] prod_ext_c;
  logic signed [ACW-1:0] acc_base_c;

  // Newest sample sits at wptr on the capture edge itself, at wptr-1 afterwards
  assign capture_c = (phase == '0);
  assign head_c    = capture_c ? wptr : wptr - PHW'(1);

  // Explicit sign extension keeps the low 32 product bits exact for any operands
  assign smp_ext_c  = {{(PW-DW){smp2[DW-1]}}, smp2};
  assign coef_ext_c = {{(PW-DW){coef2[DW-1]}}, coef2};
  assign prod_c     = smp_ext_c * coef_ext_c;
  assign prod_ext_c = {{(ACW-PW){prod3[PW-1]}}, prod3};
  assign acc_base_c = first3 ? '0 : acc;

  always_ff @(posedge clk) begin
    hold <= idata;
  end

  // Sample history RAM: one write per frame, one read per clock
  always_ff @(posedge clk) begin
    if (capture_c && nreset) hist[wptr] <= hold;
    smp2 <= hist[addr1];
  end

  fir_coeff_mem #(
    .DEPTH (TAPS),
    .DW    (DW)
  ) mem_coeff (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .raddr (tap1),
    .rdata (coef2)
  );

  // Frame control and the address / read / product / accumulate pipeline
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      phase     <= '0;
      wptr      <= '0;
      fill      <= '0;
      addr1     <= '0;
      tap1      <= '0;
      v1        <= 1'b0;
      first1    <= 1'b0;
      last1     <= 1'b0;
      live1     <= 1'b0;
      v2        <= 1'b0;
      first2    <= 1'b0;
      last2     <= 1'b0;
      live2     <= 1'b0;
      prod3     <= '0;
      v3        <= 1'b0;
      first3    <= 1'b0;
      last3     <= 1'b0;
      acc       <= '0;
      last4     <= 1'b0;
      sum5      <= '0;
      sum_v     <= 1'b0;
      out_val   <= '0;
      out_ready <= 1'b0;
    end else begin
      phase <= phase + PHW'(1);
      if (capture_c) begin
        wptr <= wptr + PHW'(1);
        if (fill != FW'(TAPS)) fill <= fill + FW'(1);
      end

      // Taps beyond the captured history count read stale RAM and are zeroed
      addr1  <= head_c - phase;
      tap1   <= phase;
      v1     <= 1'b1;
      first1 <= capture_c;
      last1  <= (phase == PHW'(TAPS - 1));
      live1  <= capture_c || ({1'b0, phase} < fill);

      v2     <= v1;
      first2 <= first1;
      last2  <= last1;
      live2  <= live1;

      prod3  <= live2 ? prod_c : '0;
      v3     <= v2;
      first3 <= first2;
      last3  <= last2;

      if (v3) acc <= acc_base_c + prod_ext_c;
      last4 <= v3 && last3;

      // Two-deep result retiming lands the update on phase 4 of the next frame
      if (last4) sum5 <= acc;
      sum_v <= last4;

      if (sum_v) out_val <= sum5;
      out_ready <= sum_v;
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
// Directed bench for fir_filter: impulse, DC fill, extremes, mid-frame reset,
// output latency and a signed mixed-tap case, all against hand-computed values.

module tb_fir_filter;

  logic               clk = 1'b0;
  logic               nreset;
  logic signed [15:0] idata;
  logic signed [47:0] out_val;
  logic               out_ready;

  int     total;
  int     bad;
  int     n_edge;
  string  tname;

  logic signed [15:0] smp_v [$];
  longint             exp_v [$];

  fir_filter dut (
    .clk       (clk),
    .nreset    (nreset),
    .idata     (idata),
    .out_val   (out_val),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One rising edge, then park on the falling edge for sampling/driving
  task automatic step();
    @(posedge clk);
    n_edge++;
    @(negedge clk);
  endtask

  task automatic load_coef(input int mode);
    for (int i = 0; i < 512; i++) begin
      logic signed [15:0] v;
      case (mode)
        0:       v = 16'(i + 1);
        1:       v = 16'sd1;
        2:       v = 16'sh8000;
        3:       v = (i == 0) ? 16'sd1 : 16'sd0;
        default: v = (i == 0) ? 16'sd3 : (i == 1) ? -16'sd5 : (i == 2) ? 16'sd7 : 16'sd0;
      endcase
      dut.mem_coeff.mem[i] <= v;
    end
  endtask

  task automatic enter_reset();
    @(negedge clk);
    nreset = 1'b0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    n_edge = -1;
  endtask

  task automatic next_out(input int j, input longint exp);
    int due;
    due = 516 + 512 * j;
    while (out_ready !== 1'b1 && n_edge < due + 8) step();
    check_val($sformatf("%s.lat%0d", tname, j), n_edge, due);
    check_val($sformatf("%s.val%0d", tname, j), out_val, exp);
    step();
    check_val($sformatf("%s.pulse%0d", tname, j), out_ready, 0);
  endtask

  // Feeds smp_v one sample per capture and checks exp_v one result per frame
  task automatic run_frames(input int nfr);
    longint prev;
    prev = 0;
    for (int j = 0; j < nfr; j++) begin
      while (n_edge < 512 * j + 256) step();
      check_val($sformatf("%s.hold%0d", tname, j), out_val, prev);
      if (j + 1 < smp_v.size()) idata = smp_v[j + 1];
      next_out(j, exp_v[j]);
      prev = exp_v[j];
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, ".val"}, out_val, 0);
    check_val({tag, ".rdy"}, out_ready, 0);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    n_edge = -1;
    nreset = 1'b0;
    idata  = 16'sd0;
    repeat (3) @(negedge clk);
    check_reset_outs("por");

    tname = "imp";
    load_coef(0);
    smp_v = '{16'sd1, 16'sd0};
    exp_v = '{1, 2, 3, 4, 5, 6};
    idata = smp_v[0];
    release_reset();
    run_frames(6);

    enter_reset();
    tname = "dc";
    load_coef(1);
    smp_v = '{16'sd100};
    exp_v = '{100, 200, 300};
    idata = smp_v[0];
    release_reset();
    run_frames(3);

    while (n_edge < 512 * 3 + 200) step();
    nreset = 1'b0;
    #1;
    check_reset_outs("mid0");
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_reset_outs($sformatf("mid%0d", i));
    end
    nreset = 1'b1;
    n_edge = -1;
    tname  = "dc_post";
    run_frames(3);

    enter_reset();
    tname = "ext";
    load_coef(2);
    smp_v = '{16'sh8000};
    exp_v = '{64'sd1073741824, 64'sd2147483648, 64'sd3221225472, 64'sd4294967296};
    idata = smp_v[0];
    release_reset();
    run_frames(4);

    enter_reset();
    tname = "lat";
    load_coef(3);
    smp_v = '{16'sd0, 16'sd0, 16'sd1000};
    exp_v = '{0, 0, 1000, 1000};
    idata = smp_v[0];
    release_reset();
    run_frames(4);

    enter_reset();
    tname = "mix";
    load_coef(4);
    smp_v = '{16'sd10, -16'sd20, 16'sd30, 16'sd32767};
    exp_v = '{30, -110, 260, 98011};
    idata = smp_v[0];
    release_reset();
    run_frames(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_filter.md
# fir_filter

Single-rate, 512-tap, 16-bit signed FIR filter that computes one multiply-accumulate per clock, giving one output per 512-clock frame. The clock therefore runs at 512 × the sample rate, for example 24 MHz for 46 875 Hz audio. The block sits between the audio capture front end, which supplies `idata`, and the downstream level/spectrum logic, which consumes `out_val` qualified by `out_ready`. Coefficients live in an internal memory that is loaded before filtering starts.

## Interface
- `TAPS`, 512: number of taps and frame length in clocks; fixed at 512, power of two.
- `clk`  in  1: single clock, at 512 × the sample rate.
- `nreset`  in  1: asynchronous, active-low reset.
- `idata`  in  16: signed input sample, two's complement.
- `out_val`  out  48: signed filter output, full precision with no rounding or saturation.
- `out_ready`  out  1: one-clock pulse marking a new `out_val`.
- Coefficient memory:
  - Submodule instance `mem_coeff` containing array `mem[0:511]` of signed 16-bit words.
  - Power-up content is all zero; reset does not change it.
  - Simulation loads it by hierarchical write (`fir_filter.mem_coeff.mem[i]`), so the array name and depth are fixed.
  - `mem[k]` multiplies the sample delayed by k samples.

## Operation
- Input path:
  - `idata` is registered into a holding register every clock.
  - `idata` is asynchronous to `clk` and changes slowly relative to it; the source guarantees stability for at least 2 clocks around each capture edge.
- Frame counter:
  - 9-bit `phase` runs 0..511 and wraps to 0.
  - The edge on which `phase` == 0 is the capture edge.
- Capture:
  - On the capture edge, the holding register is written into the 512×16 sample history RAM at `wptr`.
  - `wptr` then increments mod 512.
  - `fill` (10-bit, saturating at 512) increments.
- Computation per frame, with x[n] the newest sample:
  - y[n] = Σ_{k=0}^{511} mem[k] · x[n−k].
  - Tap k reads history address (newest − k) mod 512 during phase k.
  - Taps with k ≥ `fill` contribute 0, so history is effectively zero after reset without clearing the RAM.
- Arithmetic:
  - 16×16 signed products are 32 bits.
  - The accumulator is 48-bit signed, sign-extended. The worst case (−32768 · −32768 · 512 = 2^39) fits.
  - The accumulator clears at the start of each frame's first product.
- Pipeline:
  - Stages are address, RAM/coeff read, product register, accumulate.
  - When all 512 products are summed, the sum is copied to `out_val` and `out_ready` pulses.
- Reset, whether asserted or mid-frame:
  - Immediately clears `phase`, `wptr`, `fill`, the accumulator and pipeline valids, `out_val` (0) and `out_ready` (0).
  - Any partial frame is discarded.
  - The first capture occurs on the first clock edge after release.

## Timing
- Frame period is exactly 512 clocks; one output per frame.
- `out_val` updates on the edge 516 clocks after the capture edge of the sample it includes as x[n]. This is `phase` == 4 of the following frame.
- `out_ready` is high for exactly that one clock; it has a period of exactly 512 clocks once running.
- `out_val` holds its value between updates.
- The first `out_ready` after reset release comes 516 clocks after the first capture edge.
- Coefficient changes are not tracked frame-atomically: a `mem` write during a frame affects that frame only for taps not yet read.
- No backpressure: a consumer must sample `out_val` on or after `out_ready`, within 512 clocks.

## Test plan
- Impulse, with `mem[k]` = k+1 and `idata` = 1 for one capture, 0 otherwise:
  - Successive `out_val` are 1, 2, 3, …, 512, then 0.
  - `out_ready` period is 512 clocks.
- DC fill, with all `mem` = 1 and `idata` = 100 constant from reset:
  - `out_val` runs 100, 200, …, 51200 at the 512th output, then stays 51200.
- Extreme magnitudes, with all `mem` = −32768 and `idata` = −32768:
  - Output saturates in the fill sense to 549755813888 (2^39) with correct sign and no wrap.
- Reset mid-frame, with `nreset` low at `phase` 200 for 3 clocks:
  - `out_val` = 0 and `out_ready` = 0 during reset.
  - After release, the first `out_ready` occurs 516 clocks after the first capture and reflects only post-reset samples.
- Band-pass sanity, with band-pass coefficients (pass ~1–2 kHz) and a 16-bit sine swept 300–3900 Hz:
  - Amplitude of `out_val[35:20]` peaks in the passband and is attenuated ≥20 dB at 300 Hz and 3900 Hz.
- Latency check:
  - Step `idata` from 0 to 1000 with `mem[0]` = 1 only.
  - `out_val` becomes 1000 exactly 516 clocks after the capture edge that sampled 1000.
